// File: rtl/monopulse_pkg.sv
// Shared definitions for the monopulse feature receiver: state encoding,
// default frame-length limits and sample width.
// Optional build macro: FEATURE_AREA_EN (enables the Pulse_area accumulator).
package monopulse_pkg;

  localparam int unsigned MAX_POINTS_DEF = 251;
  localparam int unsigned MIN_POINTS_DEF = 4;
  localparam int unsigned SAMPLE_W       = 8;
  localparam int unsigned RAM_DEPTH      = 256;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SKIP,
    LOAD,
    SCAN,
    DONE,
    ERR
  } state_t;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Pulse threshold is half the peak, rounded down.
  function automatic sample_t half_threshold(input sample_t peak);
    return peak >> 1;
  endfunction

endpackage

// File: rtl/feature_sample_ram.sv
// 256x8 frame sample buffer: synchronous write, registered read (1-cycle latency).
module feature_sample_ram
  import monopulse_pkg::*;
(
  input  logic       Clk,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  sample_t mem [RAM_DEPTH];

  // Write port and registered read port; contents are not reset.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/monopulse_feature_rx.sv
// Monopulse feature receiver: captures one frame of samples, finds the peak
// while loading, then rescans the buffer to measure pulse width and rise time.
// Optional build macro: FEATURE_AREA_EN (Pulse_area accumulation; tied to 0
// when undefined).
module monopulse_feature_rx
  import monopulse_pkg::*;
#(
  parameter int unsigned MAX_POINTS = MAX_POINTS_DEF,
  parameter int unsigned MIN_POINTS = MIN_POINTS_DEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        FeatureExtraction_flag,
  input  logic [15:0] Monopulse_data1,
  output logic        FeatureExtraction_flag_reg,
  output logic [7:0]  Peak_value,
  output logic [15:0] Peak_index,
  output logic [15:0] Pulse_width,
  output logic [15:0] Rise_time,
  output logic [23:0] Pulse_area,
  output logic        Frame_error
);

  state_t      state;
  logic        armed;
  logic [7:0]  n_pts;
  logic [7:0]  cnt;
  logic [7:0]  peak_val;
  logic [7:0]  peak_idx;
  logic [15:0] pw_acc;
  logic [7:0]  first_idx;
  logic        first_found;

  logic [7:0]  sample;
  logic [7:0]  rd_data;
  logic [7:0]  thr;
  logic        hdr_ok;
  logic        start;
  logic        load_en;
  logic        fin;
  logic        hit;

  assign sample  = Monopulse_data1[7:0];
  assign thr     = half_threshold(peak_val);
  assign hit     = (rd_data >= thr);
  assign hdr_ok  = (Monopulse_data1 >= 16'(MIN_POINTS)) &&
                   (Monopulse_data1 <= 16'(MAX_POINTS));
  assign start   = (state == IDLE) && FeatureExtraction_flag && armed;
  assign load_en = (state == LOAD) && FeatureExtraction_flag;
  // SCAN runs N+2 cycles: one to prime the registered read, N to compare,
  // one to publish the results.
  assign fin     = (state == SCAN) && FeatureExtraction_flag &&
                   (cnt == n_pts + 8'd1);

  feature_sample_ram u_ram (
    .Clk     (Clk),
    .wr_en   (load_en),
    .wr_addr (cnt),
    .wr_data (sample),
    .rd_addr (cnt),
    .rd_data (rd_data)
  );

  // Frame sequencer, peak tracker, scan measurements and output registers.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state                      <= IDLE;
      armed                      <= 1'b0;
      n_pts                      <= '0;
      cnt                        <= '0;
      peak_val                   <= '0;
      peak_idx                   <= '0;
      pw_acc                     <= '0;
      first_idx                  <= '0;
      first_found                <= 1'b0;
      FeatureExtraction_flag_reg <= 1'b0;
      Peak_value                 <= '0;
      Peak_index                 <= '0;
      Pulse_width                <= '0;
      Rise_time                  <= '0;
      Frame_error                <= 1'b0;
    end else begin
      // A frame may only start after the flag has been seen low, so a frame
      // cut by reset is not picked up half-way.
      if (!FeatureExtraction_flag) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state       <= HDR;
            cnt         <= '0;
            peak_val    <= '0;
            peak_idx    <= '0;
            pw_acc      <= '0;
            first_idx   <= '0;
            first_found <= 1'b0;
          end
        end

        HDR: begin
          if (!FeatureExtraction_flag) begin
            state       <= IDLE;
            Frame_error <= 1'b1;
          end else if (hdr_ok) begin
            n_pts <= Monopulse_data1[7:0];
            state <= SKIP;
          end else begin
            state                      <= ERR;
            Frame_error                <= 1'b1;
            FeatureExtraction_flag_reg <= 1'b1;
          end
        end

        SKIP: begin
          if (!FeatureExtraction_flag) begin
            state       <= IDLE;
            Frame_error <= 1'b1;
          end else begin
            state <= LOAD;
            cnt   <= '0;
          end
        end

        LOAD: begin
          if (!FeatureExtraction_flag) begin
            state       <= IDLE;
            Frame_error <= 1'b1;
          end else begin
            // Strict compare keeps the first occurrence on ties.
            if (sample > peak_val) begin
              peak_val <= sample;
              peak_idx <= cnt;
            end
            if (cnt == n_pts - 8'd1) begin
              cnt   <= '0;
              state <= SCAN;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end

        SCAN: begin
          if (!FeatureExtraction_flag) begin
            state       <= IDLE;
            Frame_error <= 1'b1;
          end else begin
            // rd_data holds the entry addressed on the previous cycle.
            if ((cnt != 8'd0) && (cnt <= n_pts) && hit) begin
              pw_acc <= pw_acc + 16'd1;
              if (!first_found) begin
                first_found <= 1'b1;
                first_idx   <= cnt - 8'd1;
              end
            end
            if (fin) begin
              Peak_value                 <= peak_val;
              Peak_index                 <= {8'h00, peak_idx};
              Pulse_width                <= pw_acc;
              Rise_time                  <= {8'h00, peak_idx - first_idx};
              Frame_error                <= 1'b0;
              FeatureExtraction_flag_reg <= 1'b1;
              state                      <= DONE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end

        DONE, ERR: begin
          if (!FeatureExtraction_flag) begin
            state                      <= IDLE;
            FeatureExtraction_flag_reg <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef FEATURE_AREA_EN
  logic [23:0] area_acc;

  // Sum of samples accumulated while loading, published with the other features.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      area_acc   <= '0;
      Pulse_area <= '0;
    end else begin
      if (start)   area_acc   <= '0;
      if (load_en) area_acc   <= area_acc + {16'h0000, sample};
      if (fin)     Pulse_area <= area_acc;
    end
  end
`else
  assign Pulse_area = '0;
`endif

endmodule
